// File: rtl/pwm_pkg.sv
// Shared types and default widths for the multi-channel PWM block.
//   pwm_mode_t : counter shape (edge-aligned sawtooth or center-aligned triangle)
//   pwm_dir_t  : center-aligned count direction
package pwm_pkg;

    localparam int unsigned N_CH_DEF  = 2;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DIV_W_DEF = 8;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: prescaler, period counter, shadowed duty/top/mode and
// registered output.
//   clock, reset : system clock, async active-high reset
//   duty, top    : high count and counter top (captured at period boundaries)
//   div          : prescale divide, 0 disables the channel (live)
//   center       : 1 = center-aligned, 0 = edge-aligned (captured at boundaries)
//   invert       : output polarity (live)
//   pwm_out      : registered PWM output
//   period_tick  : one-clock pulse after each completed period
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] top,
    input  logic [DIV_W-1:0] div,
    input  logic             center,
    input  logic             invert,
    output logic             pwm_out,
    output logic             period_tick
);

    logic [DIV_W-1:0] pcnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_s;
    logic [CNT_W-1:0] top_s;
    pwm_mode_t        mode_s;
    pwm_dir_t         dir;

    logic             enabled_c;
    logic             tick_c;
    logic             wrap_c;
    logic             boundary_c;
    logic [CNT_W-1:0] cnt_next_c;
    pwm_dir_t         dir_next_c;

    // Prescaler tick and the counter value that tick would produce.
    always_comb begin
        enabled_c  = (div != '0);
        tick_c     = enabled_c && (pcnt == div - DIV_W'(1));
        // pcnt can sit past a freshly lowered div; wrap it without a tick.
        wrap_c     = (pcnt >= div);
        cnt_next_c = cnt;
        dir_next_c = dir;
        if (mode_s == EDGE) begin
            cnt_next_c = (cnt == top_s) ? '0 : cnt + CNT_W'(1);
        end else if (dir == UP) begin
            if (cnt == top_s) begin
                // top_s == 0 would underflow; hold at 0 so every tick is a boundary.
                cnt_next_c = (top_s == '0) ? '0 : cnt - CNT_W'(1);
                dir_next_c = DOWN;
            end else begin
                cnt_next_c = cnt + CNT_W'(1);
            end
        end else begin
            cnt_next_c = cnt - CNT_W'(1);
        end
        boundary_c = tick_c && (cnt_next_c == '0);
    end

    // Channel state and output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcnt        <= '0;
            cnt         <= '0;
            dir         <= UP;
            duty_s      <= '0;
            top_s       <= '0;
            mode_s      <= EDGE;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else if (!enabled_c) begin
            // Disabled: park the counters and keep shadows tracking the inputs
            // so the first period after enable is full length.
            pcnt        <= '0;
            cnt         <= '0;
            dir         <= UP;
            duty_s      <= duty;
            top_s       <= top;
            mode_s      <= pwm_mode_t'(center);
            pwm_out     <= invert;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= (cnt < duty_s) ^ invert;
            period_tick <= boundary_c;
            if (tick_c) begin
                pcnt <= '0;
                cnt  <= cnt_next_c;
                dir  <= dir_next_c;
                if (boundary_c) begin
                    dir    <= UP;
                    duty_s <= duty;
                    top_s  <= top;
                    mode_s <= pwm_mode_t'(center);
                end
            end else if (wrap_c) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator; each channel is an independent pwm_channel.
//   clock, reset : system clock, async active-high reset
//   duty, top    : per-channel CNT_W fields, channel i at [i*CNT_W +: CNT_W]
//   div          : per-channel DIV_W prescale, 0 disables that channel
//   center       : per-channel center-aligned select
//   invert       : per-channel live output inversion
//   pwm_out      : registered PWM outputs
//   period_tick  : per-channel one-clock period-complete pulses
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH*CNT_W-1:0] duty,
    input  logic [N_CH*CNT_W-1:0] top,
    input  logic [N_CH*DIV_W-1:0] div,
    input  logic [N_CH-1:0]       center,
    input  logic [N_CH-1:0]       invert,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH-1:0]       period_tick
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        pwm_channel #(
            .CNT_W(CNT_W),
            .DIV_W(DIV_W)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .duty       (duty[i*CNT_W +: CNT_W]),
            .top        (top[i*CNT_W +: CNT_W]),
            .div        (div[i*DIV_W +: DIV_W]),
            .center     (center[i]),
            .invert     (invert[i]),
            .pwm_out    (pwm_out[i]),
            .period_tick(period_tick[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: stimulus queues per-cycle expected
// pwm_out/period_tick values, a negedge monitor pops and compares them.
module tb_pwm_multi;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DIV_W = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [N_CH*CNT_W-1:0] duty;
    logic [N_CH*CNT_W-1:0] top;
    logic [N_CH*DIV_W-1:0] div;
    logic [N_CH-1:0]       center;
    logic [N_CH-1:0]       invert;
    logic [N_CH-1:0]       pwm_out;
    logic [N_CH-1:0]       period_tick;

    pwm_multi #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .DIV_W(DIV_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .duty       (duty),
        .top        (top),
        .div        (div),
        .center     (center),
        .invert     (invert),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    cyc;
        int    ch;
        logic  pwm;
        logic  tick;
        string nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int ch, input logic ap, input logic at,
                         input logic ep, input logic et);
        n_cmp++;
        if (ap !== ep || at !== et) begin
            n_bad++;
            $display("FAIL %s ch%0d cyc%0d: got pwm=%b tick=%b, want pwm=%b tick=%b",
                     nm, ch, cyc, ap, at, ep, et);
        end
    endtask

    // Monitor: compare every queued expectation due at this cycle.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            check(mon_e.nm, mon_e.ch, pwm_out[mon_e.ch], period_tick[mon_e.ch],
                  mon_e.pwm, mon_e.tick);
        end
    end

    // Stimulus always acts 1 time unit after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Queue one expectation per character, starting at cycle 'start'.
    task automatic expect_seq(input int ch, input int start, input string p,
                              input string t, input string nm);
        exp_t e;
        for (int i = 0; i < p.len(); i++) begin
            e.cyc  = start + i;
            e.ch   = ch;
            e.pwm  = (p[i] == "H");
            e.tick = (t[i] == "1");
            e.nm   = nm;
            q.push_back(e);
        end
    endtask

    // Park a channel disabled with new settings so its shadows load them.
    task automatic setup(input int ch, input int t, input int d, input bit c, input bit inv);
        div[ch*DIV_W +: DIV_W]  = '0;
        top[ch*CNT_W +: CNT_W]  = CNT_W'(t);
        duty[ch*CNT_W +: CNT_W] = CNT_W'(d);
        center[ch]              = c;
        invert[ch]              = inv;
        step(2);
    endtask

    task automatic enable(input int ch, input int dv, output int d0);
        div[ch*DIV_W +: DIV_W] = DIV_W'(dv);
        d0 = cyc;
    endtask

    initial begin
        #20000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int d0;
        reset  = 1'b1;
        duty   = '0;
        top    = '0;
        div    = '0;
        center = '0;
        invert = '0;
        step(1);
        expect_seq(0, cyc + 1, "LL", "00", "reset_state");
        step(2);
        reset = 1'b0;

        // Edge mode, top=4 duty=2 div=1.
        setup(0, 4, 2, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHLLLHHLLL", "0000100001", "edge_basic");
        step(10);

        // Prescaled, ch1 top=1 duty=1 div=3.
        setup(1, 1, 1, 1'b0, 1'b0);
        enable(1, 3, d0);
        expect_seq(1, d0 + 1, "HHHLLLHHHLLL", "000001000001", "prescale");
        step(12);

        // Center mode, top=3 duty=2 div=1: cnt 0,1,2,3,2,1.
        setup(0, 3, 2, 1'b1, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHLLLHHHLLLH", "000001000001", "center");
        step(12);

        // Shadowing: duty 3 -> 7 while cnt=5 only shows in the next period.
        setup(0, 9, 3, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHLLLLLLLHHHHHHHLLL", "00000000010000000001", "shadow");
        step(5);
        duty[0 +: CNT_W] = CNT_W'(7);
        step(15);

        // duty=0 gives constant low.
        setup(0, 4, 0, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "LLLLLLLLLL", "0000100001", "duty_zero");
        step(10);

        // duty=top+1 gives constant high.
        setup(0, 4, 5, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHHHHHHHH", "0000100001", "duty_full");
        step(10);

        // duty>top in center mode is also constant high.
        setup(0, 3, 4, 1'b1, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHHHH", "000001", "center_full");
        step(6);

        // Disabled with invert: output follows invert.
        setup(0, 4, 2, 1'b0, 1'b1);
        expect_seq(0, cyc + 1, "HHH", "000", "invert_disabled");
        step(3);

        // top=0 edge mode: a boundary every clock.
        setup(0, 0, 1, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHH", "1111", "top_zero");
        step(4);

        // Reset mid-period at cnt=6 of top=9 (duty=8 so the pin is high).
        setup(0, 9, 8, 1'b0, 1'b0);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHHHH", "000000", "pre_reset");
        step(6);
        reset = 1'b1;
        div   = '0;
        #1;
        check("reset_async_pwm", 0, pwm_out[0], period_tick[0], 1'b0, 1'b0);
        check("reset_async_ch1", 1, pwm_out[1], period_tick[1], 1'b0, 1'b0);
        expect_seq(0, cyc + 1, "LL", "00", "in_reset");
        step(2);
        reset = 1'b0;
        // Shadows are zero after reset; reload them while disabled, then enable.
        expect_seq(0, cyc + 1, "LL", "00", "post_reset_idle");
        step(2);
        enable(0, 1, d0);
        expect_seq(0, d0 + 1, "HHHHHHHHLL", "0000000001", "post_reset_period");
        step(10);

        step(2);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised N-channel PWM generator; successor to the single-channel fixed-width PWM in the IO block.
- Adds per channel:
  - configurable counter and prescaler widths;
  - edge-aligned or center-aligned mode;
  - output inversion;
  - shadowed duty/period registers that update only at period boundaries;
  - a period-boundary pulse.
- Sits between the register file (inputs are decoded register fields) and the IO pin mux.

Parameters:
- N_CH, 2, number of independent channels.
- CNT_W, 16, width of period counter, duty and top values.
- DIV_W, 8, width of prescaler divide value.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- duty  in  N_CH*CNT_W  per-channel high count; channel i at [i*CNT_W +: CNT_W]
- top  in  N_CH*CNT_W  per-channel counter top value
- div  in  N_CH*DIV_W  per-channel prescale; 0 = channel disabled
- center  in  N_CH  1 = center-aligned, 0 = edge-aligned
- invert  in  N_CH  1 = invert output polarity (live, not shadowed)
- pwm_out  out  N_CH  registered PWM outputs
- period_tick  out  N_CH  one-clock pulse per completed period

Behaviour:
- Reset (async):
  - all counters = 0, dir = up;
  - shadows duty_s/top_s/center_s = 0;
  - pwm_out = 0, period_tick = 0.
- Channels are fully independent; no shared state.
- Prescaler:
  - pcnt counts 0..div-1;
  - tick = (div != 0) && (pcnt == div-1); pcnt wraps to 0 on tick;
  - div = 1 gives a tick every clock.
- div changes take effect live. If pcnt >= new div, pcnt wraps to 0 on the next clock with no tick.
- Disabled (div == 0):
  - pcnt = 0, cnt = 0, dir = up;
  - shadows load the inputs every clock;
  - pwm_out <= invert[i]; period_tick = 0.
- Edge mode, on tick:
  - cnt <= (cnt == top_s) ? 0 : cnt+1;
  - period = (top_s+1)*div clocks.
- Center mode, on tick:
  - up: if cnt == top_s, dir <= down and cnt <= cnt-1; else cnt+1;
  - down: cnt-1;
  - sequence 0,1..top_s,top_s-1..1, then 0; period = 2*top_s*div clocks;
  - top_s == 0: cnt stays 0, period = div clocks.
- Boundary: any tick whose next cnt value is 0 (both modes).
  - On a boundary: dir <= up; duty_s/top_s/center_s <= inputs; period_tick <= 1 for the following clock.
  - Mid-period input changes have no effect until the next boundary.
- Output, every clock while enabled: pwm_out <= (cnt < duty_s) ^ invert.
  - One clock latency from cnt to pin.
  - duty_s == 0 gives 0% duty.
  - duty_s > top_s gives 100% duty in both modes.
- Arithmetic is unsigned, CNT_W bits; cnt never exceeds top_s.
  - A lowered top takes effect only via the shadow, so no overflow path exists.
- Enable (div 0 -> nonzero): counting starts from cnt = 0 using the shadows loaded while disabled. The first period is full length.
- Reset mid-period: outputs drop to 0 immediately (async).
  - Counting restarts on the first enabled clock after release.

Decomposition:
- pwm_pkg holds:
  - typedef pwm_mode_t enum {EDGE, CENTER};
  - typedef pwm_dir_t enum {UP, DOWN};
  - default width constants.
- Sub-module pwm_channel (one channel: prescaler, counter, shadows, output register).
- pwm_multi is a generate loop over N_CH instances plus port slicing.

Test Plan:
- Edge, ch0 top=4, duty=2, div=1 -> pwm_out[0] repeats HHLLL; period 5 clocks; period_tick every 5 clocks.
- Prescale, ch1 top=1, duty=1, div=3 -> 3 clocks high, 3 low; period_tick every 6 clocks.
- Center, top=3, duty=2, div=1 -> cnt 0,1,2,3,2,1 gives pwm pattern HHLLLH repeating; period_tick every 6 clocks.
- Shadow: top=9, div=1; change duty 3->7 at cnt=5 -> current period keeps 3 high clocks, next period shows 7.
- Boundaries:
  - duty=0 -> constant 0;
  - duty=top+1 -> constant 1;
  - invert=1 with div=0 -> pwm_out=1;
  - top=0 edge mode -> period_tick every clock.
- Reset mid-period (cnt=6 of top=9) -> pwm_out and period_tick 0 same cycle; after release the first period_tick arrives after a full (top+1)*div clocks.
